// File: rtl/ntt_pointwise_mul.sv
// Pointwise modular multiplier c[i] = a[i]*b[i] mod 8380417 over 256 coefficients, streamed through SRAM ports.
// Optional build macro PWM_BARRETT_PIPE_EN splits the Barrett reduction into two registered stages.
module ntt_pointwise_mul #(
    parameter logic [15:0] BASE_A = 16'd0,
    parameter logic [15:0] BASE_B = 16'd256,
    parameter logic [15:0] BASE_C = 16'd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_PWM,
    input  logic [23:0] QA,
    input  logic [23:0] QB,
    output logic [15:0] RA,
    output logic [15:0] RB,
    output logic [15:0] WC,
    output logic [23:0] DC,
    output logic        WEBC,
    output logic        busy_PWM,
    output logic        done_PWM
);

    localparam logic [25:0] Q26       = 26'd8380417;
    localparam logic [23:0] BARRETT_M = 24'd8396807;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  idx_reg, idx_next;
    logic        rd_valid_reg, rd_valid_next;
    logic [15:0] ra_reg, rb_reg, wc_reg;
    logic [23:0] dc_reg;
    logic        webc_reg, busy_reg, done_reg;
    logic        wr_last_reg;

    // Pipeline tags follow each read: valid bit and coefficient index.
    logic        v1_reg, v2_reg;
    logic [7:0]  i1_reg, i2_reg;
    logic [45:0] p_reg;

    logic        fin_valid;
    logic [7:0]  fin_idx;
    logic [22:0] fin_r;

    logic        unused_msb;
    assign unused_msb = QA[23] ^ QB[23];

    function automatic logic [23:0] barrett_qhat(input logic [45:0] p);
        logic [69:0] pm;
        pm = {24'd0, p} * {46'd0, BARRETT_M};
        return 24'(pm >> 46);
    endfunction

    // qhat underestimates the true quotient by at most 2, so r < 3q fits in 26 bits.
    function automatic logic [22:0] barrett_finish(input logic [25:0] p_lo, input logic [23:0] qhat);
        logic [25:0] r;
        r = p_lo - ({2'b00, qhat} * Q26);
        if (r >= Q26) r = r - Q26;
        if (r >= Q26) r = r - Q26;
        return 23'(r);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 8'd0;
            rd_valid_reg <= 1'b0;
            ra_reg       <= 16'd0;
            rb_reg       <= 16'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            rd_valid_reg <= rd_valid_next;
            busy_reg     <= (state_next == RUN) || (state_next == DRAIN);
            done_reg     <= (state_next == DONE);
            if (rd_valid_next) begin
                ra_reg <= BASE_A + {8'd0, idx_next};
                rb_reg <= BASE_B + {8'd0, idx_next};
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        rd_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_PWM) begin
                    state_next    = RUN;
                    idx_next      = 8'd0;
                    rd_valid_next = 1'b1;
                end
            end
            RUN: begin
                if (idx_reg == 8'hff) begin
                    state_next = DRAIN;
                end else begin
                    idx_next      = idx_reg + 8'd1;
                    rd_valid_next = 1'b1;
                end
            end
            DRAIN: begin
                if (wr_last_reg) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            i1_reg <= 8'd0;
            i2_reg <= 8'd0;
            p_reg  <= 46'd0;
        end else begin
            v1_reg <= rd_valid_reg;
            i1_reg <= idx_reg;
            v2_reg <= v1_reg;
            i2_reg <= i1_reg;
            p_reg  <= {23'd0, QA[22:0]} * {23'd0, QB[22:0]};
        end
    end

`ifdef PWM_BARRETT_PIPE_EN
    logic        v3_reg;
    logic [7:0]  i3_reg;
    logic [23:0] qhat_reg;
    logic [25:0] plo_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_reg   <= 1'b0;
            i3_reg   <= 8'd0;
            qhat_reg <= 24'd0;
            plo_reg  <= 26'd0;
        end else begin
            v3_reg   <= v2_reg;
            i3_reg   <= i2_reg;
            qhat_reg <= barrett_qhat(p_reg);
            plo_reg  <= p_reg[25:0];
        end
    end

    assign fin_valid = v3_reg;
    assign fin_idx   = i3_reg;
    assign fin_r     = barrett_finish(plo_reg, qhat_reg);
`else
    assign fin_valid = v2_reg;
    assign fin_idx   = i2_reg;
    assign fin_r     = barrett_finish(p_reg[25:0], barrett_qhat(p_reg));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_reg      <= 16'd0;
            dc_reg      <= 24'd0;
            webc_reg    <= 1'b1;
            wr_last_reg <= 1'b0;
        end else begin
            webc_reg    <= ~fin_valid;
            wr_last_reg <= fin_valid && (fin_idx == 8'hff);
            if (fin_valid) begin
                wc_reg <= BASE_C + {8'd0, fin_idx};
                dc_reg <= {1'b0, fin_r};
            end
        end
    end

    assign RA       = ra_reg;
    assign RB       = rb_reg;
    assign WC       = wc_reg;
    assign DC       = dc_reg;
    assign WEBC     = webc_reg;
    assign busy_PWM = busy_reg;
    assign done_PWM = done_reg;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Scoreboard bench for ntt_pointwise_mul: default-base instance plus an in-place (BASE_C = BASE_A) instance.
`timescale 1ns/1ps
module tb_ntt_pointwise_mul;

    localparam longint Q = 64'd8380417;
`ifdef PWM_BARRETT_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start1, start2, force23, do_load;
    logic [23:0] qa1, qb1, qa2, qb2, dc1, dc2;
    logic [15:0] ra1, rb1, wc1, ra2, rb2, wc2;
    logic        webc1, busy1, done1, webc2, busy2, done2;

    ntt_pointwise_mul dut (
        .clk(clk), .rst_n(rst_n), .start_PWM(start1), .QA(qa1), .QB(qb1),
        .RA(ra1), .RB(rb1), .WC(wc1), .DC(dc1), .WEBC(webc1),
        .busy_PWM(busy1), .done_PWM(done1)
    );

    ntt_pointwise_mul #(.BASE_A(16'd0), .BASE_B(16'd256), .BASE_C(16'd0)) dut_ip (
        .clk(clk), .rst_n(rst_n), .start_PWM(start2), .QA(qa2), .QB(qb2),
        .RA(ra2), .RB(rb2), .WC(wc2), .DC(dc2), .WEBC(webc2),
        .busy_PWM(busy2), .done_PWM(done2)
    );

    logic [23:0] mem_init [0:1023];
    logic [23:0] mem1 [0:1023];
    logic [23:0] mem2 [0:1023];

    always @(posedge clk) begin
        if (do_load) begin
            for (int k = 0; k < 1024; k++) begin
                mem1[k] <= mem_init[k];
                mem2[k] <= mem_init[k];
            end
        end else begin
            if (!webc1) mem1[wc1[9:0]] <= dc1;
            if (!webc2) mem2[wc2[9:0]] <= dc2;
        end
        qa1 <= mem1[ra1[9:0]] | (force23 ? 24'h800000 : 24'h000000);
        qb1 <= mem1[rb1[9:0]];
        qa2 <= mem2[ra2[9:0]];
        qb2 <= mem2[rb2[9:0]];
    end

    typedef struct {
        logic [15:0] addr;
        logic [23:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  first_wr, last_wr, done_rel, done_cnt;
    logic        busy_r1;
    logic [15:0] ra_r1, rb_r1;
    bit  timeout;

    function automatic logic [23:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        longint pa, pb;
        pa = longint'(a[22:0]);
        pb = longint'(b[22:0]);
        return 24'((pa * pb) % Q);
    endfunction

    task automatic load_mem();
        @(negedge clk); do_load = 1'b1;
        @(negedge clk); do_load = 1'b0;
    endtask

    // Pulses start on dut for one cycle and records every write and done pulse relative to that cycle.
    task automatic run1();
        wr_t w;
        obs_q.delete();
        done_cnt = 0; first_wr = -1; last_wr = -1; done_rel = -1; timeout = 1'b1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int r = 1; r <= 330; r++) begin
            if (r > 1) @(negedge clk);
            if (r == 1) begin busy_r1 = busy1; ra_r1 = ra1; rb_r1 = rb1; end
            if (!webc1) begin
                w.addr = wc1; w.data = dc1; obs_q.push_back(w);
                if (first_wr < 0) first_wr = r;
                last_wr = r;
            end
            if (done1) begin
                done_cnt++;
                if (done_rel < 0) done_rel = r;
            end
            if (done_rel >= 0 && r >= done_rel + 3) begin timeout = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (webc1 !== 1'b1) begin n_err++; $display("FAIL reset_webc: got %b expected 1", webc1); end
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done1); end
        n_vec++; if ({ra1, rb1, wc1} !== 48'd0) begin n_err++; $display("FAIL reset_addr: got RA=%0d RB=%0d WC=%0d expected 0", ra1, rb1, wc1); end
        n_vec++; if (dc1 !== 24'd0) begin n_err++; $display("FAIL reset_dc: got %0d expected 0", dc1); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: outputs checked");
    endtask

    // Patterns: 0 identity, 1 wrap (q-1)^2, 2 unreduced 2^23-1, 3 same with QA[23] forced, 4 random.
    task automatic test_patterns();
        logic [23:0] a, b, e;
        wr_t w, o;
        int bad;
        for (int m = 0; m < 5; m++) begin
            exp_q.delete();
            force23 = (m == 3);
            for (int i = 0; i < 256; i++) begin
                case (m)
                    0: begin a = 24'(i); b = 24'd1; e = 24'(i); end
                    1: begin a = 24'd8380416; b = 24'd8380416; e = 24'd1; end
                    2, 3: begin a = 24'h7fffff; b = 24'h7fffff; e = 24'd32764; end
                    default: begin
                        a = 24'($urandom_range(0, 24'h7fffff));
                        b = 24'($urandom_range(0, 24'h7fffff));
                        e = ref_mul(a, b);
                    end
                endcase
                mem_init[i] = a; mem_init[256 + i] = b; mem_init[512 + i] = 24'habcdef;
                w.addr = 16'(512 + i); w.data = e; exp_q.push_back(w);
            end
            load_mem();
            run1();
            bad = 0;
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                w = exp_q.pop_front(); o = obs_q.pop_front();
                n_vec++;
                if (o.addr !== w.addr || o.data !== w.data) begin
                    n_err++; bad++;
                    $display("FAIL pattern%0d_write: got WC=%0d DC=%0d expected WC=%0d DC=%0d", m, o.addr, o.data, w.addr, w.data);
                end
            end
            n_vec++; if (timeout || exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL pattern%0d_count: got %0d missing %0d extra (timeout=%0d) expected 0 0", m, exp_q.size(), obs_q.size(), timeout); end
            n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL pattern%0d_done_count: got %0d expected 1", m, done_cnt); end
            n_vec++; if (first_wr != 4 + LAT) begin n_err++; $display("FAIL pattern%0d_first_write: got cycle %0d expected %0d", m, first_wr, 4 + LAT); end
            n_vec++; if (last_wr != 259 + LAT) begin n_err++; $display("FAIL pattern%0d_last_write: got cycle %0d expected %0d", m, last_wr, 259 + LAT); end
            n_vec++; if (done_rel != 260 + LAT) begin n_err++; $display("FAIL pattern%0d_done_cycle: got %0d expected %0d", m, done_rel, 260 + LAT); end
            n_vec++; if (busy_r1 !== 1'b1 || ra_r1 !== 16'd0 || rb_r1 !== 16'd256) begin n_err++; $display("FAIL pattern%0d_first_read: got busy=%b RA=%0d RB=%0d expected 1 0 256", m, busy_r1, ra_r1, rb_r1); end
            $display("pattern %0d: 256 writes compared, %0d bad, done at cycle %0d", m, bad, done_rel);
        end
        force23 = 1'b0;
    endtask

    task automatic test_in_place();
        logic [23:0] a, b, e;
        logic [23:0] exp_d[$];
        int d1, d2, dcnt;
        for (int i = 0; i < 256; i++) begin
            a = 24'($urandom_range(0, 24'h7fffff));
            b = 24'($urandom_range(0, 24'h7fffff));
            mem_init[i] = a; mem_init[256 + i] = b;
            exp_d.push_back(ref_mul(a, b));
        end
        load_mem();
        @(negedge clk); start2 = 1'b1;
        d1 = -1; d2 = -1; dcnt = 0;
        for (int r = 1; r <= 700; r++) begin
            @(negedge clk);
            if (done2) begin
                dcnt++;
                if (d1 < 0) d1 = r;
                else if (d2 < 0) begin d2 = r; start2 = 1'b0; end
            end
            if (r == 260 + LAT) begin
                for (int i = 0; i < 256; i++) begin
                    e = exp_d.pop_front();
                    n_vec++;
                    if (mem2[i] !== e) begin n_err++; $display("FAIL inplace_c%0d: got %0d expected %0d", i, mem2[i], e); end
                end
            end
            if (r == 262 + LAT) begin
                n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL inplace_rerun_busy: got %b expected 1", busy2); end
            end
            if (d2 >= 0 && r >= d2 + 5) break;
        end
        start2 = 1'b0;
        n_vec++; if (dcnt != 2) begin n_err++; $display("FAIL inplace_done_count: got %0d expected 2", dcnt); end
        n_vec++; if (d1 != 260 + LAT || d2 != 521 + 2 * LAT) begin n_err++; $display("FAIL inplace_done_cycles: got %0d,%0d expected %0d,%0d", d1, d2, 260 + LAT, 521 + 2 * LAT); end
        n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL inplace_idle_after: got busy=%b expected 0", busy2); end
        $display("in_place: done pulses %0d at cycles %0d,%0d", dcnt, d1, d2);
    endtask

    task automatic test_reset_mid_run();
        logic [23:0] a, b;
        wr_t w, o;
        int bad;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = 24'($urandom_range(0, 24'h7fffff));
            b = 24'($urandom_range(0, 24'h7fffff));
            mem_init[i] = a; mem_init[256 + i] = b; mem_init[512 + i] = 24'h123456;
            w.addr = 16'(512 + i); w.data = ref_mul(a, b); exp_q.push_back(w);
        end
        load_mem();
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (99) @(negedge clk);
        n_vec++; if (webc1 !== 1'b0 || busy1 !== 1'b1) begin n_err++; $display("FAIL midrun_active: got WEBC=%b busy=%b expected 0 1", webc1, busy1); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (webc1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin n_err++; $display("FAIL midrun_reset_ctrl: got WEBC=%b busy=%b done=%b expected 1 0 0", webc1, busy1, done1); end
        n_vec++; if ({ra1, rb1, wc1} !== 48'd0 || dc1 !== 24'd0) begin n_err++; $display("FAIL midrun_reset_data: got RA=%0d RB=%0d WC=%0d DC=%0d expected 0", ra1, rb1, wc1, dc1); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (done1 !== 1'b0 || webc1 !== 1'b1) begin n_err++; $display("FAIL midrun_no_resume: got done=%b WEBC=%b expected 0 1", done1, webc1); end
        run1();
        bad = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            w = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o.addr !== w.addr || o.data !== w.data) begin
                n_err++; bad++;
                $display("FAIL restart_write: got WC=%0d DC=%0d expected WC=%0d DC=%0d", o.addr, o.data, w.addr, w.data);
            end
        end
        n_vec++; if (timeout || exp_q.size() != 0 || obs_q.size() != 0 || done_cnt != 1) begin n_err++; $display("FAIL restart_count: got missing=%0d extra=%0d done=%0d timeout=%0d expected 0 0 1 0", exp_q.size(), obs_q.size(), done_cnt, timeout); end
        $display("reset_mid_run: restart compared, %0d bad", bad);
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; force23 = 1'b0; do_load = 1'b0;
        test_reset();
        test_patterns();
        test_in_place();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
